// File: rtl/traffic_light_pkg.sv
// Shared phase encoding and default timing for the two-way traffic light controller.
package traffic_light_pkg;

   typedef enum logic [2:0] {
      N_GRN,
      N_YLW,
      RED_A,
      W_GRN,
      W_YLW,
      RED_B
   } state_t;

   localparam int DEF_GRN_CYCLES     = 8;
   localparam int DEF_MIN_GRN_CYCLES = 4;
   localparam int DEF_YLW_CYCLES     = 3;
   localparam int DEF_ALLRED_CYCLES  = 2;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic state_t next_phase(input state_t s);
      case (s)
         N_GRN:   return N_YLW;
         N_YLW:   return RED_A;
         RED_A:   return W_GRN;
         W_GRN:   return W_YLW;
         W_YLW:   return RED_B;
         default: return N_GRN;
      endcase
   endfunction

endpackage

// File: rtl/traffic_light_top_ped_request_latch.sv
// Sticky pedestrian request flag; a press on the clearing edge keeps it set.
module ped_request_latch (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic clear,
   output logic pending
);

   logic pending_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        pending_q <= 1'b0;
      else if (set)   pending_q <= 1'b1;
      else if (clear) pending_q <= 1'b0;
   end

   assign pending = pending_q;

endmodule

// File: rtl/traffic_light_top.sv
// Two-direction traffic light: six-phase Moore FSM with pedestrian-shortened greens.
module traffic_light_top
   import traffic_light_pkg::*;
#(
   parameter int GRN_CYCLES     = DEF_GRN_CYCLES,
   parameter int MIN_GRN_CYCLES = DEF_MIN_GRN_CYCLES,
   parameter int YLW_CYCLES     = DEF_YLW_CYCLES,
   parameter int ALLRED_CYCLES  = DEF_ALLRED_CYCLES
) (
   input  logic clk,
   input  logic reset_n,        // active-high despite the name
   input  logic north_ped_sig,
   input  logic west_ped_sig,
   output logic red_0,
   output logic ylw_0,
   output logic grn_0,
   output logic red_1,
   output logic ylw_1,
   output logic grn_1,
   output logic debug
);

   localparam int MAX_CYC = max2(max2(GRN_CYCLES, MIN_GRN_CYCLES), max2(YLW_CYCLES, ALLRED_CYCLES));
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic             north_pend, west_pend;
   logic             leave;
   int               limit;

   always_comb begin
      case (state_q)
         N_GRN:   limit = north_pend ? MIN_GRN_CYCLES : GRN_CYCLES;
         W_GRN:   limit = west_pend  ? MIN_GRN_CYCLES : GRN_CYCLES;
         N_YLW,
         W_YLW:   limit = YLW_CYCLES;
         default: limit = ALLRED_CYCLES;
      endcase
      // >= rather than == so a request landing after the minimum ends green at once
      leave   = int'(dwell_q) >= (limit - 1);
      state_d = leave ? next_phase(state_q) : state_q;
      dwell_d = leave ? '0 : dwell_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q <= RED_B;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
      end
   end

   ped_request_latch u_north_latch (
      .clk     (clk),
      .rst     (reset_n),
      .set     (north_ped_sig),
      .clear   ((state_q == N_YLW) && leave),
      .pending (north_pend)
   );

   ped_request_latch u_west_latch (
      .clk     (clk),
      .rst     (reset_n),
      .set     (west_ped_sig),
      .clear   ((state_q == W_YLW) && leave),
      .pending (west_pend)
   );

   assign grn_0 = (state_q == N_GRN);
   assign ylw_0 = (state_q == N_YLW);
   assign red_0 = ~(grn_0 | ylw_0);
   assign grn_1 = (state_q == W_GRN);
   assign ylw_1 = (state_q == W_YLW);
   assign red_1 = ~(grn_1 | ylw_1);
   assign debug = north_pend | west_pend;

endmodule

// File: tb/tb_traffic_light_top.sv
// Directed bench for traffic_light_top: phase lengths, pedestrian shortening, reset.
module tb_traffic_light_top;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic north_ped_sig = 1'b0;
   logic west_ped_sig = 1'b0;
   logic red_0, ylw_0, grn_0, red_1, ylw_1, grn_1, debug;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [5:0] C_NG = 6'b001_100;
   localparam logic [5:0] C_NY = 6'b010_100;
   localparam logic [5:0] C_AR = 6'b100_100;
   localparam logic [5:0] C_WG = 6'b100_001;
   localparam logic [5:0] C_WY = 6'b100_010;

   wire [5:0] lamps = {red_0, ylw_0, grn_0, red_1, ylw_1, grn_1};

   traffic_light_top dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .north_ped_sig (north_ped_sig),
      .west_ped_sig  (west_ped_sig),
      .red_0         (red_0),
      .ylw_0         (ylw_0),
      .grn_0         (grn_0),
      .red_1         (red_1),
      .ylw_1         (ylw_1),
      .grn_1         (grn_1),
      .debug         (debug)
   );

   always #5 clk = ~clk;

   // Lamp safety invariant, every cycle
   always @(negedge clk) begin
      n_cmp++;
      if (($countones(lamps[5:3]) != 1) || ($countones(lamps[2:0]) != 1) ||
          ((ylw_0 | grn_0) && (ylw_1 | grn_1))) begin
         $display("FAIL lamp_invariant: lamps=%b at %0t", lamps, $time);
         n_bad++;
      end
   end

   task automatic do_reset();
      reset_n = 1'b1;
      north_ped_sig = 1'b0;
      west_ped_sig = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
   endtask

   // Length of the current lamp pattern in cycles; stops at the first differing sample.
   task automatic measure(output logic [5:0] code, output int n);
      code = lamps;
      n = 0;
      while (lamps === code && n < 64) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [5:0] c;
      int n;
      reset_n = 1'b1;
      north_ped_sig = 1'b1;
      west_ped_sig = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (lamps !== C_AR) begin $display("FAIL reset_lamps: got %b want %b", lamps, C_AR); n_bad++; end
      n_cmp++;
      if (debug !== 1'b0) begin $display("FAIL reset_debug: got %b want 0", debug); n_bad++; end
      north_ped_sig = 1'b0;
      west_ped_sig = 1'b0;
      reset_n = 1'b0;
      measure(c, n);
      n_cmp++;
      if (c !== C_AR || n !== 2) begin $display("FAIL reset_release_red: got %b/%0d want %b/2", c, n, C_AR); n_bad++; end
      n_cmp++;
      if (lamps !== C_NG) begin $display("FAIL reset_first_green: got %b want %b", lamps, C_NG); n_bad++; end
   endtask

   task automatic test_normal_cycle();
      logic [5:0] ec [7] = '{C_AR, C_NG, C_NY, C_AR, C_WG, C_WY, C_AR};
      int el [7] = '{2, 8, 3, 2, 8, 3, 2};
      logic [5:0] c;
      int n, sum;
      do_reset();
      sum = 0;
      for (int i = 0; i < 7; i++) begin
         measure(c, n);
         if (i < 6) sum += n;
         n_cmp++;
         if (c !== ec[i] || n !== el[i]) begin
            $display("FAIL normal_phase%0d: got %b/%0d want %b/%0d", i, c, n, ec[i], el[i]); n_bad++;
         end
      end
      n_cmp++;
      if (sum !== 26) begin $display("FAIL normal_period: got %0d want 26", sum); n_bad++; end
   endtask

   task automatic test_north_ped();
      logic [5:0] c;
      int n;
      do_reset();
      measure(c, n);
      @(negedge clk);
      north_ped_sig = 1'b1;
      @(negedge clk);
      north_ped_sig = 1'b0;
      n_cmp++;
      if (debug !== 1'b1) begin $display("FAIL north_debug_set: got %b want 1", debug); n_bad++; end
      measure(c, n);
      n_cmp++;
      if (c !== C_NG || n + 2 !== 4) begin $display("FAIL north_green_len: got %b/%0d want %b/4", c, n + 2, C_NG); n_bad++; end
      n_cmp++;
      if (debug !== 1'b1) begin $display("FAIL north_debug_ylw: got %b want 1", debug); n_bad++; end
      measure(c, n);
      n_cmp++;
      if (c !== C_NY || n !== 3) begin $display("FAIL north_ylw_len: got %b/%0d want %b/3", c, n, C_NY); n_bad++; end
      n_cmp++;
      if (lamps !== C_AR || debug !== 1'b0) begin $display("FAIL north_clear_red_a: got %b/%b want %b/0", lamps, debug, C_AR); n_bad++; end
   endtask

   task automatic test_west_ped();
      logic [5:0] c;
      int n;
      do_reset();
      measure(c, n);
      west_ped_sig = 1'b1;
      @(negedge clk);
      west_ped_sig = 1'b0;
      n_cmp++;
      if (debug !== 1'b1) begin $display("FAIL west_debug_set: got %b want 1", debug); n_bad++; end
      measure(c, n);
      n_cmp++;
      if (c !== C_NG || n + 1 !== 8) begin $display("FAIL west_n_green_len: got %b/%0d want %b/8", c, n + 1, C_NG); n_bad++; end
      measure(c, n);
      measure(c, n);
      measure(c, n);
      n_cmp++;
      if (c !== C_WG || n !== 4) begin $display("FAIL west_w_green_len: got %b/%0d want %b/4", c, n, C_WG); n_bad++; end
      n_cmp++;
      if (debug !== 1'b1) begin $display("FAIL west_debug_ylw: got %b want 1", debug); n_bad++; end
      measure(c, n);
      n_cmp++;
      if (lamps !== C_AR || debug !== 1'b0) begin $display("FAIL west_clear_red_b: got %b/%b want %b/0", lamps, debug, C_AR); n_bad++; end
   endtask

   task automatic test_both_ped_red_b();
      logic [5:0] ec [6] = '{C_AR, C_NG, C_NY, C_AR, C_WG, C_WY};
      int el [6] = '{1, 4, 3, 2, 4, 3};
      logic [5:0] c;
      int n;
      do_reset();
      north_ped_sig = 1'b1;
      west_ped_sig = 1'b1;
      @(negedge clk);
      north_ped_sig = 1'b0;
      west_ped_sig = 1'b0;
      for (int i = 0; i < 6; i++) begin
         measure(c, n);
         n_cmp++;
         if (c !== ec[i] || n !== el[i]) begin
            $display("FAIL both_phase%0d: got %b/%0d want %b/%0d", i, c, n, ec[i], el[i]); n_bad++;
         end
         if (i == 2) begin
            n_cmp++;
            if (debug !== 1'b1) begin $display("FAIL both_debug_red_a: got %b want 1", debug); n_bad++; end
         end
      end
      n_cmp++;
      if (lamps !== C_AR || debug !== 1'b0) begin $display("FAIL both_debug_red_b: got %b/%b want %b/0", lamps, debug, C_AR); n_bad++; end
   endtask

   task automatic test_late_request();
      logic [5:0] c;
      int n;
      do_reset();
      measure(c, n);
      repeat (5) @(negedge clk);
      north_ped_sig = 1'b1;
      @(negedge clk);
      north_ped_sig = 1'b0;
      measure(c, n);
      n_cmp++;
      if (c !== C_NG || n + 6 !== 7) begin $display("FAIL late_green_len: got %b/%0d want %b/7", c, n + 6, C_NG); n_bad++; end
   endtask

   task automatic test_reset_mid_ylw();
      logic [5:0] c;
      int n;
      do_reset();
      repeat (5) measure(c, n);
      @(negedge clk);
      n_cmp++;
      if (lamps !== C_WY) begin $display("FAIL midrst_pre: got %b want %b", lamps, C_WY); n_bad++; end
      #2 reset_n = 1'b1;
      #1;
      n_cmp++;
      if (lamps !== C_AR || debug !== 1'b0) begin $display("FAIL midrst_async: got %b/%b want %b/0", lamps, debug, C_AR); n_bad++; end
      @(negedge clk);
      reset_n = 1'b0;
      measure(c, n);
      n_cmp++;
      if (c !== C_AR || n !== 2) begin $display("FAIL midrst_red_len: got %b/%0d want %b/2", c, n, C_AR); n_bad++; end
      measure(c, n);
      n_cmp++;
      if (c !== C_NG || n !== 8) begin $display("FAIL midrst_green_len: got %b/%0d want %b/8", c, n, C_NG); n_bad++; end
   endtask

   initial begin
      test_reset();
      test_normal_cycle();
      test_north_ped();
      test_west_ped();
      test_both_ped_red_b();
      test_late_request();
      test_reset_mid_ylw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
